// File: rtl/mult_shift_add_dp.sv
// mult_shift_add_dp: shift-and-add multiplier datapath driven by one-hot FSM commands
// Ports: clk, rst (sync, active-high); A_in/B_in operands; LD/ADD/SH/DONE commands;
// LSB_B/Z status flags to the FSM; PP live accumulator; RESULT product latched on DONE rise.
// Define MULT_DP_SIGNED_EN for two's-complement operands (magnitudes multiplied, sign reapplied).
module mult_shift_add_dp #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   A_in,
  input  logic [N-1:0]   B_in,
  input  logic           LD,
  input  logic           ADD,
  input  logic           SH,
  input  logic           DONE,
  output logic           LSB_B,
  output logic           Z,
  output logic [2*N-1:0] PP,
  output logic [2*N-1:0] RESULT
);
  logic [2*N-1:0] a_q, pp_q, result_q, fin;
  logic [N-1:0]   b_q, a_ld, b_ld;
  logic           done_q;
`ifdef MULT_DP_SIGNED_EN
  logic sign_q;
  // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude
  assign a_ld = A_in[N-1] ? -A_in : A_in;
  assign b_ld = B_in[N-1] ? -B_in : B_in;
  assign fin  = sign_q ? -pp_q : pp_q;
  always_ff @(posedge clk)
    if (rst) sign_q <= 1'b0;
    else if (LD) sign_q <= A_in[N-1] ^ B_in[N-1];
`else
  assign a_ld = A_in;
  assign b_ld = B_in;
  assign fin  = pp_q;
`endif
  assign LSB_B  = b_q[0];
  assign Z      = (b_q == '0);
  assign PP     = pp_q;
  assign RESULT = result_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      pp_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= DONE;
      if (DONE && !done_q) result_q <= fin;
      if (LD) begin
        a_q  <= {{N{1'b0}}, a_ld};
        b_q  <= b_ld;
        pp_q <= '0;
      end else begin
        // add sees the pre-shift A when ADD and SH coincide
        if (ADD) pp_q <= pp_q + a_q;
        if (SH) begin
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_shift_add_dp.sv
// tb_mult_shift_add_dp: directed self-checking bench for mult_shift_add_dp
module tb_mult_shift_add_dp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  A_in = '0, B_in = '0;
  logic        LD = 1'b0, ADD = 1'b0, SH = 1'b0, DONE = 1'b0;
  logic        LSB_B, Z;
  logic [15:0] PP, RESULT;
  int errors = 0;
  int checks = 0;

  mult_shift_add_dp #(.N(8)) dut (
    .clk(clk), .rst(rst), .A_in(A_in), .B_in(B_in),
    .LD(LD), .ADD(ADD), .SH(SH), .DONE(DONE),
    .LSB_B(LSB_B), .Z(Z), .PP(PP), .RESULT(RESULT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ld, input logic add, input logic sh, input logic done);
    LD = ld; ADD = add; SH = sh; DONE = done;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, 0, 0, 0);
    rst = 1'b0;
    chk("reset_pp", PP, 0);
    chk("reset_result", RESULT, 0);
    chk("reset_z", Z, 1);
    chk("reset_lsb", LSB_B, 0);

    A_in = 8'd5; B_in = 8'd3;
    step(1, 0, 0, 0);
    chk("ld53_z", Z, 0);
    chk("ld53_lsb", LSB_B, 1);
    chk("ld53_pp", PP, 0);
    step(0, 1, 1, 0);
    chk("53_pp1", PP, 5);
    chk("53_lsb1", LSB_B, 1);
    step(0, 1, 1, 0);
    chk("53_pp2", PP, 15);
    chk("53_z2", Z, 1);
    step(0, 0, 1, 0);
    chk("53_pp3", PP, 15);
    step(0, 0, 0, 1);
    chk("53_result", RESULT, 15);
    A_in = 8'd1; B_in = 8'd1;
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    chk("53_pp_changed", PP, 1);
    for (int i = 0; i < 28; i++) step(0, 0, 0, 1);
    chk("53_latched_once", RESULT, 15);
    step(0, 0, 0, 0);
    chk("53_hold_after_done", RESULT, 15);

    A_in = 8'd255; B_in = 8'd255;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 1, 0);
      chk($sformatf("ff_pp%0d", k), PP, 255 * ((1 << k) - 1));
    end
    chk("ff_z", Z, 1);
    step(0, 0, 0, 1);
    chk("ff_result", RESULT, 65025);
    step(0, 0, 0, 0);

    A_in = 8'd9; B_in = 8'd0;
    step(1, 0, 0, 0);
    chk("b0_z", Z, 1);
    chk("b0_lsb", LSB_B, 0);
    step(0, 0, 0, 1);
    chk("b0_result", RESULT, 0);
    step(0, 0, 0, 0);

    A_in = 8'd7; B_in = 8'd2;
    step(1, 1, 1, 0);
    chk("ldwin_pp", PP, 0);
    chk("ldwin_lsb", LSB_B, 0);
    chk("ldwin_z", Z, 0);
    step(0, 1, 0, 0);
    chk("ldwin_a", PP, 7);
    step(0, 0, 1, 0);
    chk("ldwin_b_shift", LSB_B, 1);
    step(0, 1, 0, 0);
    chk("ldwin_pp_final", PP, 21);

    A_in = 8'd3; B_in = 8'd3;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("rst_pre_result", RESULT, 3);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_pp", PP, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_z", Z, 1);
    chk("rst_lsb", LSB_B, 0);

`ifdef MULT_DP_SIGNED_EN
    A_in = 8'hFD; B_in = 8'd5;
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("sgn_pp", PP, 15);
    step(0, 0, 0, 1);
    chk("sgn_result_neg", RESULT, 16'hFFF1);
    step(0, 0, 0, 0);
    A_in = 8'h80; B_in = 8'hFF;
    step(1, 0, 0, 0);
    chk("sgn_b_mag", LSB_B, 1);
    step(0, 1, 1, 0);
    chk("sgn_z", Z, 1);
    step(0, 0, 0, 1);
    chk("sgn_result_pos", RESULT, 16'h0080);
    step(0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_shift_add_dp.md
# mult_shift_add_dp

Datapath of the shift-and-add multiplier, sitting directly downstream of the multiplier control FSM. It holds the operand and partial-product registers and executes the FSM's one-hot commands (load, add, shift). It returns the two status flags the FSM branches on: the multiplier LSB and the multiplier-exhausted flag. It latches the final product on the FSM's DONE pulse, so the processor can read a stable result after DONE drops.

## Interface
Parameters:
- N, 8, operand width in bits; product is 2N bits.

Ports:
- clk  in  1  processor clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- A_in  in  N  multiplicand from processor.
- B_in  in  N  multiplier from processor.
- LD  in  1  from FSM: load operands, clear partial product.
- ADD  in  1  from FSM: PP <= PP + A.
- SH  in  1  from FSM: A shifts left 1, B shifts right 1.
- DONE  in  1  from FSM: product ready; rising edge latches RESULT.
- LSB_B  out  1  B[0]; drives FSM in1.
- Z  out  1  high when B == 0; drives FSM in2.
- PP  out  2N  live partial product (debug/observe).
- RESULT  out  2N  latched final product, held until next DONE rising edge or reset.

## Operation
Registers:
- A: 2N-bit multiplicand, zero-extended on load.
- B: N-bit multiplier.
- PP: 2N-bit accumulator.
- RESULT: 2N-bit.
- done_q: DONE delayed one cycle, for edge detect.

Command priority per cycle: rst > LD > {ADD, SH}.
- LD: A <= {N'b0, A_in}; B <= B_in; PP <= 0. ADD and SH are ignored in the same cycle.
- ADD alone: PP <= PP + A, truncated to 2N bits. No overflow is possible for legal sequences.
- SH alone: A <= A << 1, with the MSB dropped and 0 shifted in; B <= B >> 1, with 0 shifted in.
- ADD and SH together: both apply. The add uses the pre-shift A, i.e. PP <= PP + A_old.
- No command asserted: all registers hold.

Flags and result:
- LSB_B = B[0] and Z = (B == 0). Both are combinational from registered B and carry no input paths.
- DONE rising edge (DONE & ~done_q): RESULT <= PP, or the signed result under the macro. DONE held high for many cycles (the FSM stretches it about 31 cycles) latches exactly once.
- Reset mid-operation: all registers cleared next edge. The FSM is reset by the same rst; a partial operation is abandoned. RESULT also clears to 0.

## Timing
- Reset values:
  - A=0, B=0, PP=0, RESULT=0, done_q=0.
  - LSB_B=0, Z=1, PP out=0, RESULT out=0.
- LD at edge k: Z and LSB_B reflect the new B after edge k, so they are visible to the FSM for its edge-k+1 decision.
- Per multiplier bit the FSM issues one ADD (if LSB_B) and one SH. Total cycles = 1 (LD) + up to 2 per bit until Z. An operation completes in at most 2N+1 command cycles.
- RESULT updates on the edge where DONE is first sampled high; it is stable from the next cycle on.
- PP is valid as the final product once Z=1 and no further ADD is issued.

## Configuration
- Macro MULT_DP_SIGNED_EN.
- Defined (two's-complement operands):
  - On LD, capture sign_q = A_in[N-1] ^ B_in[N-1] and load magnitudes |A_in|, |B_in| as unsigned N-bit values. -2^(N-1) maps to 2^(N-1), which fits.
  - On the DONE edge, RESULT <= sign_q ? -PP : PP, computed in 2N bits.
  - Zero product always yields RESULT=0.
  - sign_q resets to 0.
- Undefined: operands are unsigned, no sign_q register exists, and RESULT <= PP.
- Port list is identical in both builds.

## Test plan
- N=8, unsigned build, A_in=5, B_in=3: LD, ADD+SH, ADD+SH, SH, then DONE held 31 cycles.
  - Required: Z=1 after the 2nd shift, PP=15, RESULT=16'd15.
  - RESULT still 15 after DONE falls; latched once.
- A_in=255, B_in=255 with a full 8-bit sequence: RESULT=16'd65025, and PP never wraps.
- B_in=0: Z=1 on the cycle after LD. DONE with no ADD gives RESULT=0.
- LD asserted with SH and ADD in the same cycle, A_in=7, B_in=2: A=7, B=2, PP=0. The load wins and no shift occurs.
- Reset mid-operation after two commands: all registers, PP and RESULT are 0, Z=1 on the next cycle.
- Signed build, A_in=8'hFD (-3), B_in=5: RESULT=16'hFFF1 (-15).
  - A_in=8'h80, B_in=8'hFF (-1): RESULT=16'h0080.
